stopwatch_btn_ctrl: RTL and testbench

Front-end control stage for the stopwatch counter. Takes the two raw push-button inputs (start/stop and clear), synchronizes and debounces each, and produces the stopwatch's `go` run level and `clr` clear pulse. `go` toggles on each debounced press of start/stop. `clr` is a single-cycle pulse on each debounced press of clear, and it also stops the watch.

---
 rtl/stopwatch_btn_ctrl.sv | 165 ++++++++++++++++
 tb/tb_stopwatch_btn_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_btn_ctrl.sv
// rtl/stopwatch_btn_ctrl.sv - button synchronizer/debouncer front end producing stopwatch go/clr
//
// stopwatch_btn_db: one button channel.
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   btn    in  raw asynchronous, bouncy button
//   level  out registered debounced level
//   rise   out one-cycle event, high during the cycle whose edge moves WAIT1 -> ONE
//
// stopwatch_btn_ctrl: two debounce channels plus the go/clr control registers.
//   clk     in  system clock
//   reset   in  synchronous active-high reset
//   btn_ss  in  raw start/stop button
//   btn_clr in  raw clear button
//   go      out run level, toggled by start/stop presses, cleared by clear presses
//   clr     out one-cycle clear pulse after each clear press
//   ss_db   out debounced start/stop level
//   clr_db  out debounced clear level

module stopwatch_btn_db #(
    parameter int DB_TICKS = 2000000,
    parameter int CW       = 21
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic rise
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam logic [CW-1:0] LOAD = CW'(DB_TICKS - 1);

    logic          sync1;
    logic          sync2;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          level_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= ZERO;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise      = 1'b0;
        case (state)
            ZERO: begin
                if (sync2) begin
                    state_nxt = WAIT1;
                    cnt_nxt   = LOAD;
                end
            end
            WAIT1: begin
                if (!sync2) begin
                    state_nxt = ZERO;
                end else if (cnt == '0) begin
                    state_nxt = ONE;
                    rise      = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ONE: begin
                if (!sync2) begin
                    state_nxt = WAIT0;
                    cnt_nxt   = LOAD;
                end
            end
            WAIT0: begin
                if (sync2) begin
                    state_nxt = ONE;
                end else if (cnt == '0) begin
                    state_nxt = ZERO;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = ZERO;
            end
        endcase
        // Level follows the upcoming state so it is held in its own flop
        // and lands on the same edge as the state change.
        level_nxt = (state_nxt == ONE) || (state_nxt == WAIT0);
    end

endmodule

module stopwatch_btn_ctrl #(
    parameter int DB_TICKS = 2000000,
    parameter int CW       = 21
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_ss,
    input  logic btn_clr,
    output logic go,
    output logic clr,
    output logic ss_db,
    output logic clr_db
);

    logic ss_rise;
    logic clr_rise;

    stopwatch_btn_db #(
        .DB_TICKS (DB_TICKS),
        .CW       (CW)
    ) u_db_ss (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_ss),
        .level (ss_db),
        .rise  (ss_rise)
    );

    stopwatch_btn_db #(
        .DB_TICKS (DB_TICKS),
        .CW       (CW)
    ) u_db_clr (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_clr),
        .level (clr_db),
        .rise  (clr_rise)
    );

    // Clear has priority over a start/stop toggle landing on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            go  <= 1'b0;
            clr <= 1'b0;
        end else begin
            clr <= clr_rise;
            if (clr_rise) begin
                go <= 1'b0;
            end else if (ss_rise) begin
                go <= ~go;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// tb/tb_stopwatch_btn_ctrl.sv - scoreboard bench for stopwatch_btn_ctrl

module tb_stopwatch_btn_ctrl;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_ss = 1'b0;
    logic btn_clr = 1'b0;
    logic go, clr, ss_db, clr_db;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [3:0] exp_q[$];

    // Reference model: two-sample input delay, then a level that flips once
    // the delayed input has disagreed with it for DB+1 consecutive samples.
    logic [1:0] m_s1 = 2'b00;
    logic [1:0] m_s2 = 2'b00;
    logic [1:0] m_lvl = 2'b00;
    int         m_run[2];
    logic       m_go = 1'b0;
    logic       m_clr = 1'b0;

    stopwatch_btn_ctrl #(
        .DB_TICKS (DB),
        .CW       (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_ss  (btn_ss),
        .btn_clr (btn_clr),
        .go      (go),
        .clr     (clr),
        .ss_db   (ss_db),
        .clr_db  (clr_db)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        logic [1:0] raw;
        logic [1:0] ev;
        raw = {btn_clr, btn_ss};
        ev  = 2'b00;
        if (reset) begin
            m_s1 = 2'b00;
            m_s2 = 2'b00;
            m_lvl = 2'b00;
            m_run[0] = 0;
            m_run[1] = 0;
            m_go = 1'b0;
            m_clr = 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (m_s2[ch] == m_lvl[ch]) begin
                    m_run[ch] = 0;
                end else begin
                    m_run[ch] = m_run[ch] + 1;
                    if (m_run[ch] == DB + 1) begin
                        m_lvl[ch] = ~m_lvl[ch];
                        m_run[ch] = 0;
                        ev[ch] = m_lvl[ch];
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
            m_clr = ev[1];
            if (ev[1]) m_go = 1'b0;
            else if (ev[0]) m_go = ~m_go;
        end
        exp_q.push_back({m_go, m_clr, m_lvl[0], m_lvl[1]});
    endtask

    task automatic drive(input logic ss, input logic cl, input logic rst, input int n);
        for (int i = 0; i < n; i++) begin
            btn_ss  = ss;
            btn_clr = cl;
            reset   = rst;
            @(posedge clk);
            model_step();
            cyc++;
            #1;
        end
    endtask

    // Monitor: every cycle the DUT presents a fresh output word.
    initial begin
        logic [3:0] exp_v;
        logic [3:0] act_v;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {go, clr, ss_db, clr_db};
                vectors++;
                if (act_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL outputs cycle %0d {go,clr,ss_db,clr_db} actual=%b expected=%b",
                             cyc, act_v, exp_v);
                end
            end
        end
    end

    initial begin
        m_run[0] = 0;
        m_run[1] = 0;

        // Reset then idle.
        drive(0, 0, 1, 2);
        drive(0, 0, 0, 20);

        // Clean start/stop press, release, second press.
        drive(1, 0, 0, 20);
        drive(0, 0, 0, 12);
        drive(1, 0, 0, 20);
        drive(0, 0, 0, 12);

        // Bounce rejection then a stable hold.
        drive(1, 0, 0, 1);
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 2);
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 20);
        drive(0, 0, 0, 12);

        // Clear while running (go is 1 here).
        drive(0, 1, 0, 30);
        drive(0, 0, 0, 12);

        // Simultaneous presses with go = 0.
        drive(1, 1, 0, 20);
        drive(0, 0, 0, 12);

        // Reset mid-window with the press held through it.
        drive(1, 0, 0, 4);
        drive(1, 0, 1, 1);
        drive(1, 0, 0, 20);
        drive(0, 0, 0, 12);

        // Random bouncy holds of varied length, occasional reset.
        for (int k = 0; k < 400; k++) begin
            logic ss, cl, rst;
            int   len;
            ss  = 1'($urandom_range(0, 1));
            cl  = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 60) == 0);
            len = (rst != 0) ? 1 : int'($urandom_range(1, 12));
            drive(ss, cl, rst, len);
        end
        drive(0, 0, 0, 12);

        // Let the monitor drain, with a bound.
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
